// File: rtl/fg_norm_gate.sv
// Keygen rejection gate: sums ||f||^2 and ||g||^2 from poly_small_sqnorm and holds an accept/reject verdict until ack.
// Optional reject counter is enabled by defining FG_NORM_ATTEMPT_CNT_EN; otherwise attempts is tied to 0.
module fg_norm_gate #(
  parameter int          logn  = 9,
  parameter int unsigned BOUND = 16823,
  localparam int         s_bit = (logn == 9) ? 21 : 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             s_valid,
  input  logic [s_bit-1:0] s,
  output logic             done,
  output logic             accept,
  output logic [s_bit:0]   norm,
  input  logic             ack,
  output logic             err,
  output logic [7:0]       attempts
);

  typedef enum logic [1:0] {IDLE, WAIT_F, WAIT_G, RESULT} state_t;

  state_t         state, state_next;
  logic [s_bit:0] acc;
  logic [s_bit:0] sum;
  logic           sum_lt;
  logic           take_f;
  logic           take_g;
  logic           proto_err;

  // One extra bit of headroom: f + g at full scale cannot wrap.
  assign sum    = acc + {1'b0, s};
  assign sum_lt = 32'(sum) < BOUND;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    take_f     = 1'b0;
    take_g     = 1'b0;
    proto_err  = 1'b0;
    case (state)
      IDLE: begin
        if (ena) state_next = WAIT_F;
        proto_err = s_valid;
      end
      WAIT_F: begin
        if (ena) begin
          state_next = WAIT_F;
        end else if (s_valid) begin
          take_f     = 1'b1;
          state_next = WAIT_G;
        end
      end
      WAIT_G: begin
        if (ena) begin
          state_next = WAIT_F;
        end else if (s_valid) begin
          take_g     = 1'b1;
          state_next = RESULT;
        end
      end
      RESULT: begin
        if (ack) state_next = ena ? WAIT_F : IDLE;
        proto_err = s_valid;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      norm   <= '0;
      accept <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == RESULT);
      if (ena)         acc <= '0;
      else if (take_f) acc <= {1'b0, s};
      // Verdict registers only move on entry to RESULT and hold afterwards.
      if (take_g) begin
        norm   <= sum;
        accept <= sum_lt;
      end
      if (ena)            err <= 1'b0;
      else if (proto_err) err <= 1'b1;
    end
  end

`ifdef FG_NORM_ATTEMPT_CNT_EN
  logic [7:0] attempts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      attempts_q <= '0;
    end else if (take_g && !sum_lt) begin
      if (attempts_q != 8'hFF) attempts_q <= attempts_q + 8'd1;
    end else if (state == RESULT && ack && accept) begin
      attempts_q <= '0;
    end
  end

  assign attempts = attempts_q;
`else
  assign attempts = '0;
`endif

endmodule
